lock_sequencer: RTL and testbench
=================================

# lock_sequencer

Sequencing controller for the combination-lock datapath: accepts strobed BCD digits, compares them against a stored, reprogrammable 6-digit code, and drives the display-mode select for the HEX driver. It adds what the base lock lacks: an explicit entry strobe, failed-attempt counting with timed lockout, and a code-programming mode entered only from OPEN. It sits between debounced switch/key inputs and the 7-segment display mux.

## Interface
- N_DIGITS, 6: digits per code.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout.
- LOCKOUT_CYCLES, 1000: lockout duration in clk cycles, ≥1.
- DEFAULT_CODE, 24'h722297: code loaded at reset. BCD; the first-entered digit is in the most-significant nibble.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- digit  in  4  BCD digit value.
- digit_valid  in  1  one-cycle strobe; `digit` is sampled this cycle.
- clear  in  1  leave OPEN/CLOSED, or abort PROGRAM.
- prog_req  in  1  request code programming; honoured only in OPEN.
- display_mode  out  2  00 digit entry, 01 CLOSED, 10 OPEN, 11 locked out.
- entry_count  out  3  digits accepted in the current entry/program sequence.
- fail_count  out  2  consecutive failed attempts.
- locked_out  out  1  high while in LOCKOUT.
- digit_err  out  1  one-cycle pulse when a strobed digit is >9.

## Operation
- States: ENTRY, OPEN, CLOSED, LOCKOUT, PROGRAM. All outputs are registered.
- Reset (rst_n=0 at a rising edge):
  - state=ENTRY, idx=0, mismatch=0, fail_count=0, timer=0, code=DEFAULT_CODE.
  - display_mode=00, entry_count=0, locked_out=0, digit_err=0.
  - Reset overrides every other input and aborts any sequence in progress.
- Digit validity: a strobe with digit>9 pulses digit_err, then is otherwise ignored (no idx change, no compare). The pulse occurs in every state except LOCKOUT.
- ENTRY, on each valid strobe:
  - Compare against code digit idx; any mismatch sets the sticky mismatch flag.
  - idx increments, and entry_count follows idx.
  - On the N_DIGITS-th digit:
    - If all digits matched, go to OPEN; fail_count←0.
    - Otherwise go to CLOSED; fail_count←fail_count+1.
    - If the new fail_count equals MAX_FAIL, go to LOCKOUT instead of CLOSED, with timer←LOCKOUT_CYCLES-1.
  - idx and mismatch clear whenever ENTRY is left.
- `clear` in ENTRY: idx←0 and mismatch←0 (restart entry); fail_count is unchanged.
- OPEN:
  - Digit strobes are ignored.
  - clear goes to ENTRY.
  - prog_req goes to PROGRAM with idx←0.
  - If clear and prog_req arrive together, clear wins.
- CLOSED: digit strobes are ignored; clear goes to ENTRY.
- LOCKOUT:
  - All inputs except rst_n are ignored.
  - timer decrements every cycle.
  - In the cycle timer=0, go to ENTRY with fail_count←0.
- PROGRAM:
  - Each valid digit is written into a shadow register at nibble idx; idx increments.
  - After the N_DIGITS-th digit, code←shadow and the state goes to ENTRY (the lock relocks).
  - clear aborts: code is unchanged, state returns to OPEN.
- Same-cycle priority: rst_n > clear > prog_req > digit_valid.
- display_mode: ENTRY/PROGRAM=00, CLOSED=01, OPEN=10, LOCKOUT=11.

## Timing
- Strobe at edge k: state, entry_count, fail_count, display_mode and digit_err are visible after edge k. Latency is 1 cycle; there is no combinational path from input to output.
- The final digit at edge k gives display_mode=01, 10 or 11 after edge k.
- LOCKOUT entered at edge k is left at edge k+LOCKOUT_CYCLES; locked_out is high for exactly LOCKOUT_CYCLES cycles.
- Back-to-back strobes on consecutive cycles are all accepted; no minimum spacing.
- digit_err deasserts on the cycle after its pulse unless the next cycle also carries an invalid strobe.
- A code committed by PROGRAM at edge k is used for compares from edge k+1.

## Test plan
- Reset, then strobe 7,2,2,2,9,7 → display_mode=10 and fail_count=0 one cycle after the 6th strobe; entry_count counts 1..6 over the strobes.
- Strobe 7,2,2,2,9,6 → display_mode=01, fail_count=1; further strobes are ignored; clear → display_mode=00, entry_count=0.
- LOCKOUT_CYCLES=8, three wrong sequences →
  - locked_out=1 and display_mode=11 for exactly 8 cycles;
  - strobes and clear during lockout have no effect;
  - afterwards state is ENTRY with fail_count=0.
- Open with 722297, then prog_req, then 1,2,3,4,5,6 → display_mode=00. Entering 722297 then gives 01; after clear, 123456 gives 10.
- Strobe digit=10 after two valid digits → digit_err=1 for one cycle, entry_count stays 2; completing with 2,2,9,7 opens.
- PROGRAM with three digits entered, then rst_n=0 for one edge → all outputs at reset values and code=722297; clear during PROGRAM (separate run) returns to OPEN with the code unchanged.

Source files
------------

// File: rtl/lock_sequencer.sv
// lock_sequencer: strobed BCD code entry with failed-attempt lockout and
// in-field code programming. Every output is registered; next values are
// computed in one combinational block and captured in one clocked block.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_ENTRY   | collecting digits and comparing them against the stored code
// ST_OPEN    | correct code entered; clear relocks, prog_req reprograms
// ST_CLOSED  | wrong code entered; waits for clear
// ST_LOCKOUT | MAX_FAIL consecutive failures; inputs ignored until timeout
// ST_PROGRAM | collecting a new code into the shadow register
module lock_sequencer #(
    parameter int                    N_DIGITS       = 6,
    parameter int                    MAX_FAIL       = 3,
    parameter int                    LOCKOUT_CYCLES = 1000,
    parameter logic [4*N_DIGITS-1:0] DEFAULT_CODE   = 24'h722297
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       clear,
    input  logic       prog_req,
    output logic [1:0] display_mode,
    output logic [2:0] entry_count,
    output logic [1:0] fail_count,
    output logic       locked_out,
    output logic       digit_err
);

    localparam int         TW   = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [2:0] LAST = 3'(N_DIGITS - 1);

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_OPEN,
        ST_CLOSED,
        ST_LOCKOUT,
        ST_PROGRAM
    } state_t;

    state_t                state, state_n;
    logic [2:0]            idx, idx_n;
    logic                  mismatch, mismatch_n;
    logic [1:0]            fail_n;
    logic [TW-1:0]         timer, timer_n;
    logic [4*N_DIGITS-1:0] code, code_n, shadow, shadow_n;
    logic [2:0]            count_n;
    logic                  err_n;
    logic                  digit_ok;
    logic [3:0]            code_digit;

    function automatic logic [1:0] mode_of(state_t s);
        case (s)
            ST_CLOSED:  return 2'b01;
            ST_OPEN:    return 2'b10;
            ST_LOCKOUT: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // Next-state and next-output computation; priority clear > prog_req > digit.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        mismatch_n = mismatch;
        fail_n     = fail_count;
        timer_n    = timer;
        code_n     = code;
        shadow_n   = shadow;
        count_n    = entry_count;
        err_n      = 1'b0;
        digit_ok   = (digit <= 4'd9);
        // first-entered digit lives in the most-significant nibble
        code_digit = code[4*(N_DIGITS-1-int'(idx)) +: 4];

        case (state)
            ST_ENTRY: begin
                if (clear) begin
                    idx_n      = '0;
                    mismatch_n = 1'b0;
                    count_n    = '0;
                end else if (digit_valid) begin
                    if (!digit_ok) begin
                        err_n = 1'b1;
                    end else begin
                        count_n = idx + 3'd1;
                        if (idx == LAST) begin
                            idx_n      = '0;
                            mismatch_n = 1'b0;
                            if (!mismatch && digit == code_digit) begin
                                state_n = ST_OPEN;
                                fail_n  = '0;
                            end else begin
                                fail_n = fail_count + 2'd1;
                                if (fail_n == 2'(MAX_FAIL)) begin
                                    state_n = ST_LOCKOUT;
                                    timer_n = TW'(LOCKOUT_CYCLES - 1);
                                end else begin
                                    state_n = ST_CLOSED;
                                end
                            end
                        end else begin
                            idx_n = idx + 3'd1;
                            if (digit != code_digit) mismatch_n = 1'b1;
                        end
                    end
                end
            end
            ST_OPEN: begin
                if (clear) begin
                    state_n = ST_ENTRY;
                    count_n = '0;
                end else if (prog_req) begin
                    state_n = ST_PROGRAM;
                    idx_n   = '0;
                    count_n = '0;
                end else if (digit_valid && !digit_ok) begin
                    err_n = 1'b1;
                end
            end
            ST_CLOSED: begin
                if (clear) begin
                    state_n = ST_ENTRY;
                    count_n = '0;
                end else if (digit_valid && !digit_ok) begin
                    err_n = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (timer == '0) begin
                    state_n = ST_ENTRY;
                    fail_n  = '0;
                    count_n = '0;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            ST_PROGRAM: begin
                if (clear) begin
                    state_n = ST_OPEN;
                    idx_n   = '0;
                    count_n = '0;
                end else if (digit_valid) begin
                    if (!digit_ok) begin
                        err_n = 1'b1;
                    end else begin
                        shadow_n[4*(N_DIGITS-1-int'(idx)) +: 4] = digit;
                        if (idx == LAST) begin
                            code_n  = shadow_n;
                            state_n = ST_ENTRY;
                            idx_n   = '0;
                            count_n = '0;
                        end else begin
                            idx_n   = idx + 3'd1;
                            count_n = idx + 3'd1;
                        end
                    end
                end
            end
            default: begin
                state_n = ST_ENTRY;
                idx_n   = '0;
                count_n = '0;
            end
        endcase
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_ENTRY;
            idx          <= '0;
            mismatch     <= 1'b0;
            fail_count   <= '0;
            timer        <= '0;
            code         <= DEFAULT_CODE;
            shadow       <= '0;
            display_mode <= 2'b00;
            entry_count  <= '0;
            locked_out   <= 1'b0;
            digit_err    <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            mismatch     <= mismatch_n;
            fail_count   <= fail_n;
            timer        <= timer_n;
            code         <= code_n;
            shadow       <= shadow_n;
            display_mode <= mode_of(state_n);
            entry_count  <= count_n;
            locked_out   <= (state_n == ST_LOCKOUT);
            digit_err    <= err_n;
        end
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed scenarios plus a randomized run checked
// against a queue-based reference model of the lock's behaviour.
module tb_lock_sequencer;

    localparam int LOCK = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] digit;
    logic       digit_valid;
    logic       clear;
    logic       prog_req;
    logic [1:0] display_mode;
    logic [2:0] entry_count;
    logic [1:0] fail_count;
    logic       locked_out;
    logic       digit_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lock_sequencer #(.LOCKOUT_CYCLES(LOCK)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .clear        (clear),
        .prog_req     (prog_req),
        .display_mode (display_mode),
        .entry_count  (entry_count),
        .fail_count   (fail_count),
        .locked_out   (locked_out),
        .digit_err    (digit_err)
    );

    // Reference model: mode uses the display encoding (0 entry, 1 closed,
    // 2 open, 3 lockout); programming is a flag on top of mode 0.
    int m_code[6];
    int m_entry[$];
    int m_prog[$];
    int m_mode;
    bit m_prog_on;
    int m_fails;
    int m_lock_left;
    int m_count;
    bit m_err;

    task automatic model_reset();
        m_code      = '{7, 2, 2, 2, 9, 7};
        m_entry.delete();
        m_prog.delete();
        m_mode      = 0;
        m_prog_on   = 1'b0;
        m_fails     = 0;
        m_lock_left = 0;
        m_count     = 0;
        m_err       = 1'b0;
    endtask

    task automatic model_step(input bit v, input int d, input bit c, input bit p);
        bit same;
        m_err = 1'b0;
        if (m_mode == 3) begin
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_mode  = 0;
                m_fails = 0;
                m_count = 0;
            end
        end else if (m_prog_on) begin
            if (c) begin
                m_prog_on = 1'b0;
                m_mode    = 2;
                m_count   = 0;
            end else if (v) begin
                if (d > 9) m_err = 1'b1;
                else begin
                    m_prog.push_back(d);
                    m_count = m_prog.size();
                    if (m_prog.size() == 6) begin
                        foreach (m_code[i]) m_code[i] = m_prog[i];
                        m_prog_on = 1'b0;
                        m_count   = 0;
                    end
                end
            end
        end else if (m_mode == 0) begin
            if (c) begin
                m_entry.delete();
                m_count = 0;
            end else if (v) begin
                if (d > 9) m_err = 1'b1;
                else begin
                    m_entry.push_back(d);
                    m_count = m_entry.size();
                    if (m_entry.size() == 6) begin
                        same = 1'b1;
                        foreach (m_code[i]) if (m_entry[i] != m_code[i]) same = 1'b0;
                        if (same) begin
                            m_mode  = 2;
                            m_fails = 0;
                        end else begin
                            m_fails++;
                            if (m_fails == 3) begin
                                m_mode      = 3;
                                m_lock_left = LOCK;
                            end else m_mode = 1;
                        end
                        m_entry.delete();
                    end
                end
            end
        end else if (m_mode == 2) begin
            if (c) begin
                m_mode  = 0;
                m_count = 0;
            end else if (p) begin
                m_prog_on = 1'b1;
                m_mode    = 0;
                m_prog.delete();
                m_count   = 0;
            end else if (v && d > 9) m_err = 1'b1;
        end else begin
            if (c) begin
                m_mode  = 0;
                m_count = 0;
            end else if (v && d > 9) m_err = 1'b1;
        end
    endtask

    task automatic tick(input bit v, input int d, input bit c, input bit p);
        digit_valid = v;
        digit       = 4'(d);
        clear       = c;
        prog_req    = p;
        @(posedge clk);
        model_step(v, d, c, p);
        @(negedge clk);
        digit_valid = 1'b0;
        clear       = 1'b0;
        prog_req    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic enter6(input int s[6]);
        for (int i = 0; i < 6; i++) tick(1'b1, s[i], 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        digit_valid = 1'b1;
        digit       = 4'd7;
        clear       = 1'b1;
        prog_req    = 1'b1;
        rst_n       = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        digit_valid = 1'b0;
        clear = 1'b0;
        prog_req = 1'b0;
        n_cmp++;
        if (display_mode !== 2'b00) begin n_bad++; $display("FAIL reset_mode got %0d want 0", display_mode); end
        n_cmp++;
        if (entry_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", entry_count); end
        n_cmp++;
        if (fail_count !== 2'd0 || locked_out !== 1'b0 || digit_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags got fail=%0d lock=%0b err=%0b want 0/0/0", fail_count, locked_out, digit_err);
        end
    endtask

    task automatic test_open();
        int s[6] = '{7, 2, 2, 2, 9, 7};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, s[i], 1'b0, 1'b0);
            n_cmp++;
            if (entry_count !== 3'(i + 1)) begin n_bad++; $display("FAIL open_count[%0d] got %0d want %0d", i, entry_count, i + 1); end
        end
        n_cmp++;
        if (display_mode !== 2'b10 || fail_count !== 2'd0) begin
            n_bad++;
            $display("FAIL open_result got mode=%0d fail=%0d want 2/0", display_mode, fail_count);
        end
        tick(1'b0, 0, 1'b1, 1'b0);
        n_cmp++;
        if (display_mode !== 2'b00 || entry_count !== 3'd0) begin
            n_bad++;
            $display("FAIL open_clear got mode=%0d count=%0d want 0/0", display_mode, entry_count);
        end
    endtask

    task automatic test_closed();
        int s[6] = '{7, 2, 2, 2, 9, 6};
        do_reset();
        enter6(s);
        n_cmp++;
        if (display_mode !== 2'b01 || fail_count !== 2'd1) begin
            n_bad++;
            $display("FAIL closed_result got mode=%0d fail=%0d want 1/1", display_mode, fail_count);
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 7, 1'b0, 1'b0);
        n_cmp++;
        if (display_mode !== 2'b01 || fail_count !== 2'd1 || entry_count !== 3'(m_count)) begin
            n_bad++;
            $display("FAIL closed_ignore got mode=%0d fail=%0d count=%0d want 1/1/%0d", display_mode, fail_count, entry_count, m_count);
        end
        tick(1'b0, 0, 1'b1, 1'b0);
        n_cmp++;
        if (display_mode !== 2'b00 || entry_count !== 3'd0 || fail_count !== 2'd1) begin
            n_bad++;
            $display("FAIL closed_clear got mode=%0d count=%0d fail=%0d want 0/0/1", display_mode, entry_count, fail_count);
        end
    endtask

    task automatic test_lockout();
        int bad[6] = '{1, 1, 1, 1, 1, 1};
        int good[6] = '{7, 2, 2, 2, 9, 7};
        int cyc = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            enter6(bad);
            if (k < 2) tick(1'b0, 0, 1'b1, 1'b0);
        end
        n_cmp++;
        if (display_mode !== 2'b11 || fail_count !== 2'd3) begin
            n_bad++;
            $display("FAIL lock_enter got mode=%0d fail=%0d want 3/3", display_mode, fail_count);
        end
        if (locked_out) cyc = 1;
        for (int i = 0; i < 3 * LOCK && locked_out; i++) begin
            tick(1'b1, $urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_cmp++;
            if (digit_err !== 1'b0) begin n_bad++; $display("FAIL lock_err got %0b want 0", digit_err); end
            if (locked_out) begin
                cyc++;
                n_cmp++;
                if (display_mode !== 2'b11) begin n_bad++; $display("FAIL lock_mode got %0d want 3", display_mode); end
            end
        end
        n_cmp++;
        if (cyc !== LOCK) begin n_bad++; $display("FAIL lock_cycles got %0d want %0d", cyc, LOCK); end
        n_cmp++;
        if (display_mode !== 2'b00 || fail_count !== 2'd0) begin
            n_bad++;
            $display("FAIL lock_exit got mode=%0d fail=%0d want 0/0", display_mode, fail_count);
        end
        enter6(good);
        n_cmp++;
        if (display_mode !== 2'b10) begin n_bad++; $display("FAIL lock_then_open got %0d want 2", display_mode); end
    endtask

    task automatic test_program();
        int old_c[6] = '{7, 2, 2, 2, 9, 7};
        int new_c[6] = '{1, 2, 3, 4, 5, 6};
        do_reset();
        enter6(old_c);
        tick(1'b0, 0, 1'b0, 1'b1);
        n_cmp++;
        if (display_mode !== 2'b00 || entry_count !== 3'd0) begin
            n_bad++;
            $display("FAIL prog_enter got mode=%0d count=%0d want 0/0", display_mode, entry_count);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, new_c[i], 1'b0, 1'b0);
            n_cmp++;
            if (entry_count !== 3'(i + 1)) begin n_bad++; $display("FAIL prog_count[%0d] got %0d want %0d", i, entry_count, i + 1); end
        end
        tick(1'b1, new_c[5], 1'b0, 1'b0);
        n_cmp++;
        if (display_mode !== 2'b00) begin n_bad++; $display("FAIL prog_commit got %0d want 0", display_mode); end
        enter6(old_c);
        n_cmp++;
        if (display_mode !== 2'b01) begin n_bad++; $display("FAIL prog_old_code got %0d want 1", display_mode); end
        tick(1'b0, 0, 1'b1, 1'b0);
        enter6(new_c);
        n_cmp++;
        if (display_mode !== 2'b10) begin n_bad++; $display("FAIL prog_new_code got %0d want 2", display_mode); end
    endtask

    task automatic test_digit_err();
        int rest[4] = '{2, 2, 9, 7};
        do_reset();
        tick(1'b1, 7, 1'b0, 1'b0);
        tick(1'b1, 2, 1'b0, 1'b0);
        tick(1'b1, 10, 1'b0, 1'b0);
        n_cmp++;
        if (digit_err !== 1'b1 || entry_count !== 3'd2) begin
            n_bad++;
            $display("FAIL err_pulse got err=%0b count=%0d want 1/2", digit_err, entry_count);
        end
        tick(1'b1, 15, 1'b0, 1'b0);
        n_cmp++;
        if (digit_err !== 1'b1) begin n_bad++; $display("FAIL err_back_to_back got %0b want 1", digit_err); end
        tick(1'b0, 0, 1'b0, 1'b0);
        n_cmp++;
        if (digit_err !== 1'b0 || entry_count !== 3'd2) begin
            n_bad++;
            $display("FAIL err_drop got err=%0b count=%0d want 0/2", digit_err, entry_count);
        end
        for (int i = 0; i < 4; i++) tick(1'b1, rest[i], 1'b0, 1'b0);
        n_cmp++;
        if (display_mode !== 2'b10) begin n_bad++; $display("FAIL err_then_open got %0d want 2", display_mode); end
    endtask

    task automatic test_prog_abort();
        int good[6] = '{7, 2, 2, 2, 9, 7};
        do_reset();
        enter6(good);
        tick(1'b0, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) tick(1'b1, i, 1'b0, 1'b0);
        do_reset();
        n_cmp++;
        if (display_mode !== 2'b00 || entry_count !== 3'd0 || fail_count !== 2'd0 || locked_out !== 1'b0 || digit_err !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_reset got mode=%0d count=%0d fail=%0d lock=%0b err=%0b want all 0",
                     display_mode, entry_count, fail_count, locked_out, digit_err);
        end
        enter6(good);
        n_cmp++;
        if (display_mode !== 2'b10) begin n_bad++; $display("FAIL abort_reset_code got %0d want 2", display_mode); end
        tick(1'b0, 0, 1'b0, 1'b1);
        tick(1'b1, 4, 1'b0, 1'b0);
        tick(1'b1, 4, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b1, 1'b0);
        n_cmp++;
        if (display_mode !== 2'b10) begin n_bad++; $display("FAIL abort_clear got %0d want 2", display_mode); end
        tick(1'b0, 0, 1'b1, 1'b0);
        enter6(good);
        n_cmp++;
        if (display_mode !== 2'b10) begin n_bad++; $display("FAIL abort_code_kept got %0d want 2", display_mode); end
    endtask

    task automatic test_random();
        bit v, c, p;
        int d, r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 9);
            if (!m_prog_on && m_mode == 0 && r < 7) d = m_code[m_entry.size()];
            else if (r < 8) d = $urandom_range(10, 15);
            else d = $urandom_range(0, 9);
            c = ($urandom_range(0, 24) == 0);
            p = ($urandom_range(0, 7) == 0);
            tick(v, d, c, p);
            n_cmp++;
            if (display_mode !== 2'(m_mode) || fail_count !== 2'(m_fails) ||
                locked_out !== (m_mode == 3) || digit_err !== m_err) begin
                n_bad++;
                $display("FAIL rand[%0d] got mode=%0d fail=%0d lock=%0b err=%0b want %0d/%0d/%0b/%0b",
                         n, display_mode, fail_count, locked_out, digit_err, m_mode, m_fails, m_mode == 3, m_err);
            end
            if (m_mode == 0) begin
                n_cmp++;
                if (entry_count !== 3'(m_count)) begin
                    n_bad++;
                    $display("FAIL rand_count[%0d] got %0d want %0d", n, entry_count, m_count);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        digit       = 4'd0;
        digit_valid = 1'b0;
        clear       = 1'b0;
        prog_req    = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_open();
        test_closed();
        test_lockout();
        test_program();
        test_digit_err();
        test_prog_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
